async_elastic_buffer: RTL and testbench

- Parametrised successor to the single-slot `reg` dataflow node. Replaces chains of `reg` nodes used for path balancing in generated `arf` graphs with one DEPTH-entry FIFO.
- Uses the same pull handshake:
  - Left side: issues `req_l` upstream and receives an `ack_l` pulse with `din`.
  - Right side: receives `req_r` from each consumer and answers with an `ack_r` pulse carrying `dout`.
- Adds independent per-consumer fan-out and preloaded initial tokens for feedback loops.

---
 rtl/async_elastic_buffer.sv | 135 +++++++++++++
 tb/tb_async_elastic_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module      : async_elastic_buffer
// Description : DEPTH-entry pull-handshake FIFO. It replaces chains of single
//               slot reg nodes. There is one upstream request/ack pair and
//               OUTPUT_SIZE independent downstream request/ack pairs, and the
//               buffer can be preloaded with INIT_TOKENS copies of INIT_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module async_elastic_buffer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 4,
    parameter int                    OUTPUT_SIZE = 1,
    parameter int                    INIT_TOKENS = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         req_l,
    input  logic                         ack_l,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [OUTPUT_SIZE-1:0]       req_r,
    output logic [OUTPUT_SIZE-1:0]       ack_r,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    // Pointers need at least one bit, even when DEPTH=1.
    localparam int                c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_LVL_W     = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_WR_RESET  = c_PTR_W'(INIT_TOKENS % DEPTH);
    localparam logic [c_LVL_W-1:0] c_DEPTH_LVL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_INIT_LVL  = c_LVL_W'(INIT_TOKENS);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [c_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_LVL_W-1:0]     level_q, level_d;
    logic                   req_l_q, req_l_d;
    logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
    logic [OUTPUT_SIZE-1:0] sent_q, sent_d;
    logic                   w_push;
    logic                   w_pop;

    // A push happens only when the ack answers our own outstanding request.
    assign w_push = req_l_q & ack_l;

    // Retire the head one edge after the last consumer's ack pulse has ended.
    // This keeps dout stable for every cycle in which an ack is visible.
    assign w_pop  = (level_q != '0) & (&sent_q) & ~(|ack_r_q);

    // Next-state logic for the handshakes, occupancy and pointers.
    always_comb begin
        req_l_d  = req_l_q;
        level_d  = level_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ack_r_d  = '0;
        sent_d   = sent_q;

        // A new request is raised only when the previous ack has gone low and
        // a slot is free, so at most one request is ever outstanding.
        if (req_l_q && ack_l) begin
            req_l_d = 1'b0;
        end else if (!req_l_q && !ack_l && (level_q < c_DEPTH_LVL)) begin
            req_l_d = 1'b1;
        end

        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + c_PTR_W'(1);
        end

        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + c_PTR_W'(1);
        end

        if (w_push && !w_pop) begin
            level_d = level_q + c_LVL_W'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - c_LVL_W'(1);
        end

        // Each consumer gets a one-cycle ack for the current head, and gets it
        // only once. A dropped req_r after the ack does not undo the delivery.
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            if ((level_q != '0) && !sent_q[j] && !ack_r_q[j] && req_r[j]) begin
                ack_r_d[j] = 1'b1;
                sent_d[j]  = 1'b1;
            end
        end

        if (w_pop) begin
            sent_d = '0;
        end
    end

    // Control state register. The asynchronous reset drops any in-flight transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_l_q  <= 1'b0;
            ack_r_q  <= '0;
            sent_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= c_WR_RESET;
            level_q  <= c_INIT_LVL;
        end else begin
            req_l_q  <= req_l_d;
            ack_r_q  <= ack_r_d;
            sent_q   <= sent_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage. Preloaded tokens take INIT_VALUE at reset; the remaining slots
    // take it too, which is harmless because they are unoccupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_async_elastic_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_async_elastic_buffer
// Description : Randomised bench for async_elastic_buffer. It drives four
//               instances (depth 4, depth 4 preloaded, depth 1, depth 3), each
//               with two consumers. The reference model is an ordered word
//               list per instance, made of the preloaded tokens followed by
//               every pushed word. Each consumer must walk through that list
//               in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_elastic_buffer;

    localparam int c_N    = 4;
    localparam int c_MAXW = 4096;
    localparam int c_DEP  [c_N] = '{4, 4, 1, 3};
    localparam int c_INIT [c_N] = '{0, 2, 0, 0};
    localparam logic [31:0] c_IVAL [c_N] = '{32'd0, 32'd7, 32'd0, 32'd0};

    logic        clk = 1'b0;
    logic        rst;
    wire         req_l_w [c_N];
    logic        ack_l_r [c_N];
    logic [31:0] din_r   [c_N];
    logic [1:0]  req_r_r [c_N];
    wire  [1:0]  ack_r_w [c_N];
    wire  [31:0] dout_w  [c_N];
    wire  [2:0]  lvl0_w;
    wire  [2:0]  lvl1_w;
    wire  [0:0]  lvl2_w;
    wire  [1:0]  lvl3_w;

    // Reference model and stimulus control.
    logic [31:0] exp_mem [c_N][c_MAXW];
    logic [31:0] first5  [c_N][2][5];
    int          exp_n   [c_N];
    int          cidx    [c_N][2];
    int          pcnt    [c_N];
    int          pushes  [c_N];
    int          aligned_cnt [c_N];
    logic [1:0]  prev_ack [c_N];
    int          prod_mode [c_N];   // 0 off, 1 random, 2 aligned with pop edge
    int          prod_pct  [c_N];
    int          plimit    [c_N];
    int          cmode     [c_N][2]; // 0 off, 1 always, 2 every 5th cycle, 3 random
    int          cyc;
    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    async_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .OUTPUT_SIZE(2),
                           .INIT_TOKENS(0), .INIT_VALUE(32'd0)) u_dut0 (
        .clk(clk), .rst(rst), .req_l(req_l_w[0]), .ack_l(ack_l_r[0]), .din(din_r[0]),
        .req_r(req_r_r[0]), .ack_r(ack_r_w[0]), .dout(dout_w[0]), .level(lvl0_w));

    async_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .OUTPUT_SIZE(2),
                           .INIT_TOKENS(2), .INIT_VALUE(32'd7)) u_dut1 (
        .clk(clk), .rst(rst), .req_l(req_l_w[1]), .ack_l(ack_l_r[1]), .din(din_r[1]),
        .req_r(req_r_r[1]), .ack_r(ack_r_w[1]), .dout(dout_w[1]), .level(lvl1_w));

    async_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(1), .OUTPUT_SIZE(2),
                           .INIT_TOKENS(0), .INIT_VALUE(32'd0)) u_dut2 (
        .clk(clk), .rst(rst), .req_l(req_l_w[2]), .ack_l(ack_l_r[2]), .din(din_r[2]),
        .req_r(req_r_r[2]), .ack_r(ack_r_w[2]), .dout(dout_w[2]), .level(lvl2_w));

    async_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(3), .OUTPUT_SIZE(2),
                           .INIT_TOKENS(0), .INIT_VALUE(32'd0)) u_dut3 (
        .clk(clk), .rst(rst), .req_l(req_l_w[3]), .ack_l(ack_l_r[3]), .din(din_r[3]),
        .req_r(req_r_r[3]), .ack_r(ack_r_w[3]), .dout(dout_w[3]), .level(lvl3_w));

    function automatic int lvl(input int k);
        case (k)
            0:       return int'(lvl0_w);
            1:       return int'(lvl1_w);
            2:       return int'(lvl2_w);
            default: return int'(lvl3_w);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model(input int k);
        exp_n[k] = c_INIT[k];
        for (int i = 0; i < c_INIT[k]; i++) exp_mem[k][i] = c_IVAL[k];
        for (int j = 0; j < 2; j++) begin
            cidx[k][j] = 0;
            for (int i = 0; i < 5; i++) first5[k][j][i] = 32'hDEAD_BEEF;
        end
        pcnt[k]        = 0;
        pushes[k]      = 0;
        aligned_cnt[k] = 0;
        prev_ack[k]    = 2'b00;
        ack_l_r[k]     = 1'b0;
        din_r[k]       = 32'd0;
        req_r_r[k]     = 2'b00;
    endtask

    // Monitor and drivers. Everything is sampled and driven on the falling edge.
    initial begin
        cyc = 0;
        for (int k = 0; k < c_N; k++) reset_model(k);
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < c_N; k++) begin
                if (rst) begin
                    reset_model(k);
                end else begin
                    logic go;
                    for (int j = 0; j < 2; j++) begin
                        if (ack_r_w[k][j]) begin
                            check_eq($sformatf("ack_pulse u%0d c%0d", k, j), {31'd0, prev_ack[k][j]}, 32'd0);
                            if (cidx[k][j] < exp_n[k]) begin
                                check_eq($sformatf("order u%0d c%0d w%0d", k, j, cidx[k][j]),
                                         dout_w[k], exp_mem[k][cidx[k][j]]);
                            end else begin
                                check_eq($sformatf("ahead_of_head u%0d c%0d", k, j),
                                         32'(cidx[k][j]), 32'(exp_n[k] - 1));
                            end
                            if (cidx[k][j] < 5) first5[k][j][cidx[k][j]] = dout_w[k];
                            cidx[k][j]++;
                        end
                    end
                    check_eq($sformatf("level_bound u%0d", k), 32'(lvl(k) <= c_DEP[k]), 32'd1);
                    if (lvl(k) == c_DEP[k]) begin
                        check_eq($sformatf("req_l_full u%0d", k), {31'd0, req_l_w[k]}, 32'd0);
                    end
                    // Producer: one-cycle ack pulse answering an open request.
                    go = 1'b0;
                    if (ack_l_r[k]) begin
                        ack_l_r[k] = 1'b0;
                    end else if (req_l_w[k] && exp_n[k] < c_MAXW) begin
                        if (prod_mode[k] == 1)
                            go = (pushes[k] < plimit[k]) && ($urandom_range(99) < prod_pct[k]);
                        else if (prod_mode[k] == 2)
                            go = (prev_ack[k] == 2'b11) && (ack_r_w[k] == 2'b00);
                    end
                    if (go) begin
                        ack_l_r[k] = 1'b1;
                        din_r[k]   = pcnt[k];
                        exp_mem[k][exp_n[k]] = pcnt[k];
                        exp_n[k]++;
                        pcnt[k]++;
                        pushes[k]++;
                        if (prod_mode[k] == 2) aligned_cnt[k]++;
                    end else if (!ack_l_r[k]) begin
                        din_r[k] = $urandom;
                    end
                    prev_ack[k] = ack_r_w[k];
                    for (int j = 0; j < 2; j++) begin
                        case (cmode[k][j])
                            1:       req_r_r[k][j] = 1'b1;
                            2:       req_r_r[k][j] = (cyc % 5 == 0);
                            3:       req_r_r[k][j] = ($urandom_range(99) < 60);
                            default: req_r_r[k][j] = 1'b0;
                        endcase
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < c_N; k++) begin
            check_eq($sformatf("rst_req_l u%0d", k), {31'd0, req_l_w[k]}, 32'd0);
            check_eq($sformatf("rst_ack_r u%0d", k), {30'd0, ack_r_w[k]}, 32'd0);
            check_eq($sformatf("rst_level u%0d", k), 32'(lvl(k)), 32'(c_INIT[k]));
        end
        check_eq("rst_dout_preload", dout_w[1], 32'd7);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic all_idle();
        for (int k = 0; k < c_N; k++) begin
            prod_mode[k] = 0;
            prod_pct[k]  = 100;
            plimit[k]    = 1 << 30;
            cmode[k][0]  = 0;
            cmode[k][1]  = 0;
        end
    endtask

    task automatic wait_deliv(input int k, input int n, input int bound, input string tag);
        int t;
        t = 0;
        while ((cidx[k][0] < n || cidx[k][1] < n) && t < bound) begin
            @(negedge clk);
            #2;
            t++;
        end
        check_eq(tag, 32'(cidx[k][0] >= n && cidx[k][1] >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int t;
        int seq [5];
        n_chk  = 0;
        n_pass = 0;
        all_idle();
        @(negedge clk);
        #1;
        do_reset();

        // Fill while the consumers are stalled, then drain in order.
        prod_mode[0] = 1;
        repeat (20) @(negedge clk);
        #2;
        check_eq("fill_level", 32'(lvl(0)), 32'd4);
        check_eq("fill_pushes", 32'(pushes[0]), 32'd4);
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            #2;
            if (req_l_w[0]) hi++;
        end
        check_eq("fill_req_l_idle", 32'(hi), 32'd0);
        check_eq("fill_pushes_after", 32'(pushes[0]), 32'd4);
        cmode[0][0] = 1;
        cmode[0][1] = 1;
        wait_deliv(0, 12, 500, "fill_drain");

        // Preloaded tokens come out first.
        all_idle();
        @(negedge clk);
        #1;
        do_reset();
        prod_mode[1] = 1;
        cmode[1][0]  = 1;
        cmode[1][1]  = 1;
        wait_deliv(1, 5, 300, "preload_deliv");
        seq = '{7, 7, 0, 1, 2};
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("preload_seq c0 %0d", i), first5[1][0][i], 32'(seq[i]));
            check_eq($sformatf("preload_seq c1 %0d", i), first5[1][1][i], 32'(seq[i]));
        end

        // Skewed fan-out: a fast consumer and a slow one.
        all_idle();
        @(negedge clk);
        #1;
        do_reset();
        prod_mode[0] = 1;
        prod_pct[0]  = 70;
        cmode[0][0]  = 1;
        cmode[0][1]  = 2;
        wait_deliv(0, 20, 3000, "skew_deliv");

        // A push on the same edge as a pop leaves the level unchanged.
        all_idle();
        @(negedge clk);
        #1;
        do_reset();
        prod_mode[0] = 1;
        plimit[0]    = 2;
        t = 0;
        while (lvl(0) != 2 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        repeat (3) @(negedge clk);
        #2;
        check_eq("simul_setup_level", 32'(lvl(0)), 32'd2);
        check_eq("simul_setup_req_l", {31'd0, req_l_w[0]}, 32'd1);
        prod_mode[0] = 2;
        cmode[0][0]  = 1;
        cmode[0][1]  = 1;
        for (int r = 1; r <= 5; r++) begin
            t = 0;
            while (aligned_cnt[0] < r && t < 100) begin
                @(negedge clk);
                #2;
                t++;
            end
            check_eq($sformatf("simul_push_seen %0d", r), 32'(aligned_cnt[0] >= r), 32'd1);
            @(posedge clk);
            #1;
            check_eq($sformatf("simul_level %0d", r), 32'(lvl(0)), 32'd2);
        end
        prod_mode[0] = 0;
        wait_deliv(0, 7, 300, "simul_drain");

        // Reset between edges while a request and an ack are both high.
        all_idle();
        @(negedge clk);
        #1;
        do_reset();
        prod_mode[0] = 1;
        prod_pct[0]  = 50;
        cmode[0][0]  = 1;
        cmode[0][1]  = 1;
        prod_mode[1] = 1;
        prod_pct[1]  = 50;
        cmode[1][0]  = 1;
        cmode[1][1]  = 3;
        t = 0;
        hi = 0;
        while (t < 1000) begin
            @(negedge clk);
            #2;
            t++;
            if (req_l_w[0] && ack_r_w[0][0]) begin
                hi = 1;
                break;
            end
        end
        check_eq("midrst_found", 32'(hi), 32'd1);
        #1;
        do_reset();
        wait_deliv(0, 5, 500, "midrst_deliv0");
        wait_deliv(1, 5, 500, "midrst_deliv1");
        check_eq("midrst_first_u0", first5[0][0][0], 32'd0);
        check_eq("midrst_first_u1", first5[1][0][0], 32'd7);

        // Depth 1 long stream and depth 3 pointer wrap, run together.
        all_idle();
        @(negedge clk);
        #1;
        do_reset();
        prod_mode[2] = 1;
        prod_pct[2]  = 80;
        cmode[2][0]  = 1;
        cmode[2][1]  = 3;
        prod_mode[3] = 1;
        prod_pct[3]  = 60;
        cmode[3][0]  = 3;
        cmode[3][1]  = 2;
        wait_deliv(3, 30, 2000, "depth3_deliv");
        wait_deliv(2, 1000, 30000, "depth1_deliv");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
